// File: rtl/pipe_rx_data.sv
// Packs 8/16/32-bit PIPE RX chunks into 32-bit descrambler words (optional PIPE_RX_DROP_CNT_EN drop counter).
// Strobe 1 pclk after the final chunk; no backpressure, partial words dropped on RxValid loss or generation change.
module pipe_rx_data #(
  parameter int pipe_width_gen1 = 8,
  parameter int pipe_width_gen2 = 8,
  parameter int pipe_width_gen3 = 16,
  parameter int pipe_width_gen4 = 32,
  parameter int pipe_width_gen5 = 32
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic [2:0]  generation,
  input  logic [31:0] RxData,
  input  logic [3:0]  RxDataK,
  input  logic        RxDataValid,
  input  logic        RxValid,
  output logic [31:0] descramblerDataIn,
  output logic [3:0]  descramblerDataK,
  output logic        descramblerDataValid
`ifdef PIPE_RX_DROP_CNT_EN
  ,
  output logic [7:0]  rxDropCount
`endif
);

  logic [2:0]  gen_q;
  logic [1:0]  cnt;
  logic [31:0] asm_dat;
  logic [3:0]  asm_k;
  logic [2:0]  wbytes;
  logic [1:0]  last_cnt;
  logic        gen_ok;
  logic        discard;
  logic        last;
  logic [31:0] word_nxt;
  logic [3:0]  k_nxt;
  int          base;

  // Bytes per chunk for the live generation; zero marks an invalid generation.
  always_comb begin
    wbytes = 3'd0;
    case (generation)
      3'd1:    wbytes = 3'(pipe_width_gen1 / 8);
      3'd2:    wbytes = 3'(pipe_width_gen2 / 8);
      3'd3:    wbytes = 3'(pipe_width_gen3 / 8);
      3'd4:    wbytes = 3'(pipe_width_gen4 / 8);
      3'd5:    wbytes = 3'(pipe_width_gen5 / 8);
      default: wbytes = 3'd0;
    endcase
  end

  always_comb begin
    last_cnt = 2'd0;
    case (wbytes)
      3'd1:    last_cnt = 2'd3;
      3'd2:    last_cnt = 2'd1;
      default: last_cnt = 2'd0;
    endcase
  end

  assign gen_ok  = (wbytes != 3'd0);
  assign discard = (generation != gen_q) || !RxValid;
  assign last    = (cnt == last_cnt);

  // Merge the incoming chunk into the partial word at byte offset cnt*wbytes.
  always_comb begin
    word_nxt = asm_dat;
    k_nxt    = asm_k;
    base     = int'(cnt) * int'(wbytes);
    for (int b = 0; b < 4; b++) begin
      if (b >= base && b < base + int'(wbytes)) begin
        word_nxt[b*8 +: 8] = RxData[(b-base)*8 +: 8];
        k_nxt[b]           = RxDataK[b-base];
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      gen_q                <= 3'd0;
      cnt                  <= 2'd0;
      asm_dat              <= 32'd0;
      asm_k                <= 4'd0;
      descramblerDataIn    <= 32'd0;
      descramblerDataK     <= 4'd0;
      descramblerDataValid <= 1'b0;
    end else begin
      gen_q                <= generation;
      descramblerDataValid <= 1'b0;
      if (discard || !gen_ok) begin
        cnt     <= 2'd0;
        asm_dat <= 32'd0;
        asm_k   <= 4'd0;
      end else if (RxDataValid) begin
        if (last) begin
          descramblerDataIn    <= word_nxt;
          descramblerDataK     <= k_nxt;
          descramblerDataValid <= 1'b1;
          cnt                  <= 2'd0;
          asm_dat              <= 32'd0;
          asm_k                <= 4'd0;
        end else begin
          asm_dat <= word_nxt;
          asm_k   <= k_nxt;
          cnt     <= cnt + 2'd1;
        end
      end
    end
  end

`ifdef PIPE_RX_DROP_CNT_EN
  always_ff @(posedge pclk) begin
    if (reset) begin
      rxDropCount <= 8'd0;
    end else if (discard && cnt != 2'd0 && rxDropCount != 8'hFF) begin
      rxDropCount <= rxDropCount + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_rx_data.sv
// Directed bench for pipe_rx_data: byte-queue reference model checked every cycle plus literal word checks.
module tb_pipe_rx_data;

  logic        pclk = 1'b0;
  logic        reset;
  logic [2:0]  generation;
  logic [31:0] RxData;
  logic [3:0]  RxDataK;
  logic        RxDataValid;
  logic        RxValid;
  logic [31:0] descramblerDataIn;
  logic [3:0]  descramblerDataK;
  logic        descramblerDataValid;
`ifdef PIPE_RX_DROP_CNT_EN
  logic [7:0]  rxDropCount;
`endif

  always #5 pclk = ~pclk;

  pipe_rx_data dut (
    .pclk                 (pclk),
    .reset                (reset),
    .generation           (generation),
    .RxData               (RxData),
    .RxDataK              (RxDataK),
    .RxDataValid          (RxDataValid),
    .RxValid              (RxValid),
    .descramblerDataIn    (descramblerDataIn),
    .descramblerDataK     (descramblerDataK),
    .descramblerDataValid (descramblerDataValid)
`ifdef PIPE_RX_DROP_CNT_EN
    ,
    .rxDropCount          (rxDropCount)
`endif
  );

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  // Reference: bytes per generation as widths, pending bytes kept as a queue.
  int          wtab [8] = '{0, 8, 8, 16, 32, 32, 0, 0};
  logic [8:0]  pend [$];
  logic [2:0]  prev_gen;
  logic        exp_vld;
  logic [31:0] exp_dat;
  logic [3:0]  exp_k;
  int          exp_drop;
  int          mw;
  logic [31:0] got_dat [$];
  logic [3:0]  got_k [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge pclk) begin
    exp_vld = 1'b0;
    if (reset) begin
      pend.delete();
      prev_gen = 3'd0;
      exp_dat  = 32'd0;
      exp_k    = 4'd0;
      exp_drop = 0;
      started  = 1'b1;
    end else begin
      mw = wtab[generation];
      if (generation != prev_gen || !RxValid) begin
        if (pend.size() != 0 && exp_drop < 255) exp_drop++;
        pend.delete();
      end else if (mw == 0) begin
        pend.delete();
      end else if (RxDataValid) begin
        for (int b = 0; b < mw / 8; b++) pend.push_back({RxDataK[b], RxData[b*8 +: 8]});
        if (pend.size() == 4) begin
          exp_dat = {pend[3][7:0], pend[2][7:0], pend[1][7:0], pend[0][7:0]};
          exp_k   = {pend[3][8], pend[2][8], pend[1][8], pend[0][8]};
          exp_vld = 1'b1;
          pend.delete();
        end
      end
      prev_gen = generation;
    end
  end

  always @(negedge pclk) begin
    if (started) begin
      check("strobe", {31'd0, descramblerDataValid}, {31'd0, exp_vld});
      check("data", descramblerDataIn, exp_dat);
      check("kflags", {28'd0, descramblerDataK}, {28'd0, exp_k});
`ifdef PIPE_RX_DROP_CNT_EN
      check("dropcnt", {24'd0, rxDropCount}, 32'(exp_drop));
`endif
      if (descramblerDataValid === 1'b1) begin
        got_dat.push_back(descramblerDataIn);
        got_k.push_back(descramblerDataK);
      end
    end
  end

  task automatic step(input logic r, input logic [2:0] g, input logic rv, input logic dv,
                      input logic [31:0] d, input logic [3:0] k);
    reset       = r;
    generation  = g;
    RxValid     = rv;
    RxDataValid = dv;
    RxData      = d;
    RxDataK     = k;
    @(posedge pclk);
    #1;
  endtask

  task automatic expect_one(input string name, input logic [31:0] w, input logic [3:0] k);
    check({name, " count"}, 32'(got_dat.size()), 32'd1);
    if (got_dat.size() != 0) begin
      check({name, " word"}, got_dat[0], w);
      check({name, " k"}, {28'd0, got_k[0]}, {28'd0, k});
    end
    got_dat.delete();
    got_k.delete();
  endtask

  initial begin
    step(1, 3'd1, 0, 0, 32'd0, 4'd0);
    step(1, 3'd1, 0, 0, 32'd0, 4'd0);
    check("reset strobe", {31'd0, descramblerDataValid}, 32'd0);
    check("reset data", descramblerDataIn, 32'd0);

    // Gen1: upper lanes carry junk that must be ignored.
    step(0, 3'd1, 1, 0, 32'd0, 4'd0);
    step(0, 3'd1, 1, 1, 32'hABCDEF11, 4'b1111);
    step(0, 3'd1, 1, 1, 32'hFFFFFF22, 4'b1110);
    step(0, 3'd1, 1, 1, 32'h00000033, 4'b0000);
    step(0, 3'd1, 1, 1, 32'h12345644, 4'b1110);
    step(0, 3'd1, 1, 0, 32'd0, 4'd0);
    expect_one("gen1", 32'h44332211, 4'b0001);

    // Gen3 with a data-valid gap between halves.
    step(0, 3'd3, 1, 0, 32'd0, 4'd0);
    step(0, 3'd3, 1, 1, 32'h0000BEEF, 4'd0);
    step(0, 3'd3, 1, 0, 32'h11111111, 4'd0);
    step(0, 3'd3, 1, 1, 32'h0000DEAD, 4'd0);
    step(0, 3'd3, 1, 0, 32'd0, 4'd0);
    expect_one("gen3", 32'hDEADBEEF, 4'b0000);

    // Gen5 back-to-back full-width words.
    step(0, 3'd5, 1, 0, 32'd0, 4'd0);
    for (int i = 0; i < 4; i++) step(0, 3'd5, 1, 1, 32'hA0 + 32'(i), 4'd0);
    step(0, 3'd5, 1, 0, 32'd0, 4'd0);
    check("gen5 count", 32'(got_dat.size()), 32'd4);
    for (int i = 0; i < 4 && i < got_dat.size(); i++) check("gen5 word", got_dat[i], 32'hA0 + 32'(i));
    got_dat.delete();
    got_k.delete();

    // RxValid drop discards the first two bytes.
    step(0, 3'd1, 1, 0, 32'd0, 4'd0);
    step(0, 3'd1, 1, 1, 32'h11, 4'd0);
    step(0, 3'd1, 1, 1, 32'h22, 4'd0);
    step(0, 3'd1, 0, 1, 32'h99, 4'd0);
    step(0, 3'd1, 1, 1, 32'h55, 4'd0);
    step(0, 3'd1, 1, 1, 32'h66, 4'd0);
    step(0, 3'd1, 1, 1, 32'h77, 4'd0);
    step(0, 3'd1, 1, 1, 32'h88, 4'd0);
    step(0, 3'd1, 1, 0, 32'd0, 4'd0);
    expect_one("rxvalid drop", 32'h88776655, 4'b0000);
`ifdef PIPE_RX_DROP_CNT_EN
    check("drop after rxvalid", {24'd0, rxDropCount}, 32'd1);
`endif

    // Generation switch mid-word: switch-cycle data ignored.
    step(0, 3'd1, 1, 1, 32'h11, 4'd0);
    step(0, 3'd1, 1, 1, 32'h22, 4'd0);
    step(0, 3'd4, 1, 1, 32'hCAFEF00D, 4'd0);
    step(0, 3'd4, 1, 1, 32'h12345678, 4'd0);
    step(0, 3'd4, 1, 0, 32'd0, 4'd0);
    expect_one("gen switch", 32'h12345678, 4'b0000);
`ifdef PIPE_RX_DROP_CNT_EN
    check("drop after switch", {24'd0, rxDropCount}, 32'd2);
`endif

    // Reset mid-word.
    step(0, 3'd1, 1, 0, 32'd0, 4'd0);
    step(0, 3'd1, 1, 1, 32'hE1, 4'd0);
    step(0, 3'd1, 1, 1, 32'hE2, 4'd0);
    step(0, 3'd1, 1, 1, 32'hE3, 4'd0);
    step(1, 3'd1, 1, 1, 32'hE4, 4'd0);
    check("mid reset strobe", {31'd0, descramblerDataValid}, 32'd0);
    check("mid reset data", descramblerDataIn, 32'd0);
    check("mid reset k", {28'd0, descramblerDataK}, 32'd0);
`ifdef PIPE_RX_DROP_CNT_EN
    check("mid reset drop", {24'd0, rxDropCount}, 32'd0);
`endif
    got_dat.delete();
    got_k.delete();
    step(0, 3'd1, 1, 0, 32'd0, 4'd0);
    step(0, 3'd1, 1, 1, 32'h01, 4'd0);
    step(0, 3'd1, 1, 1, 32'h02, 4'd1);
    step(0, 3'd1, 1, 1, 32'h03, 4'd0);
    step(0, 3'd1, 1, 1, 32'h04, 4'd1);
    step(0, 3'd1, 1, 0, 32'd0, 4'd0);
    expect_one("post reset", 32'h04030201, 4'b1010);

    // Invalid generation accepts nothing.
    for (int i = 0; i < 5; i++) step(0, 3'd7, 1, 1, 32'h5A5A5A5A, 4'hF);
    step(0, 3'd1, 1, 0, 32'd0, 4'd0);
    step(0, 3'd1, 1, 0, 32'd0, 4'd0);
    check("gen7 count", 32'(got_dat.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_rx_data.md
Name: pipe_rx_data

Overview:
- Receive-side counterpart of the PIPE TX data path. Collects PHY-width PIPE receive words (8/16/32 bits, selected by generation) into 32-bit words for the descrambler.
- Width per generation set by parameters. Sits between the PIPE RX interface and the descrambler, clocked by pclk.
- Discards partial words on loss of RxValid or on a generation change.

Parameters:
- pipe_width_gen1, 8, PIPE RX width in Gen1; legal values 8/16/32
- pipe_width_gen2, 8, PIPE RX width in Gen2
- pipe_width_gen3, 16, PIPE RX width in Gen3
- pipe_width_gen4, 32, PIPE RX width in Gen4
- pipe_width_gen5, 32, PIPE RX width in Gen5

Ports:
- pclk  input  1  PIPE parallel clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- generation  input  3  link generation, 1..5; any other value is invalid
- RxData  input  32  PIPE receive data; only low W bits meaningful (W = width for the current generation)
- RxDataK  input  4  K-symbol flags; only low W/8 bits meaningful
- RxDataValid  input  1  RxData qualifier; low = gap cycle
- RxValid  input  1  PHY symbol/block lock indication
- descramblerDataIn  output  32  assembled word; first-received byte in [7:0]
- descramblerDataK  output  4  K flag per byte of descramblerDataIn
- descramblerDataValid  output  1  one-cycle strobe per assembled word

Behaviour:
- Reset: all outputs 0, chunk counter 0, assembly registers 0, registered generation = 0.
- Chunk definitions:
  - W = pipe_width_genN for the current generation; N = 32/W chunks per word (4, 2 or 1).
  - cnt counts 0..N-1.
- Accept condition: RxValid=1 and RxDataValid=1 and generation in 1..5.
- On accept:
  - RxData[W-1:0] is stored at bit offset cnt*W; RxDataK[W/8-1:0] is stored at offset cnt*W/8.
  - If cnt==N-1: next cycle drives descramblerDataIn/K with the full word, descramblerDataValid=1, cnt->0.
  - Otherwise cnt increments.
- Latency: 1 pclk from acceptance of the final chunk to the strobe. With W=32, every accepted word appears 1 cycle later; back-to-back accepts give a continuous strobe.
- descramblerDataValid is high for exactly one cycle per word. descramblerDataIn/K hold their last value while the strobe is low.
- Gap (RxValid=1, RxDataValid=0): no accept, cnt and partial word retained, no strobe.
- RxValid=0: cnt->0 and the partial word is discarded. No strobe, unless the final chunk was accepted in the prior cycle; that strobe still fires.
- Generation change (generation differs from its registered copy):
  - Takes priority over accept in the same cycle: partial word discarded, cnt->0, input that cycle ignored.
  - Accumulation resumes the next cycle at the new width.
- Invalid generation (0, 6, 7): no accepts, cnt held at 0, no strobe.
- Reset mid-word: everything is cleared the next edge, with no output of partial data.
- Reset has priority over all other events.
- Width rules: bits of RxData/RxDataK above W are ignored. Output byte k comes from the chunk holding byte k.

Optional Feature:
- Macro: PIPE_RX_DROP_CNT_EN
- When defined:
  - Adds output port rxDropCount [7:0].
  - Counts each discard of a non-empty partial word (cnt!=0) caused by RxValid=0 or a generation change.
  - Saturates at 255; cleared by reset.
- When undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- Gen1, bytes 0x11,0x22,0x33,0x44 over 4 accepts, RxDataK=1 on the first -> one strobe 1 cycle after the 4th: descramblerDataIn=0x44332211, descramblerDataK=4'b0001.
- Gen3, 16-bit words 0xBEEF then 0xDEAD with one RxDataValid=0 gap between -> single strobe, descramblerDataIn=0xDEADBEEF, exactly one strobe cycle.
- Gen5, 4 consecutive 32-bit accepts 0xA0..0xA3 -> 4 consecutive strobe cycles, each 1 cycle late, data matching in order.
- Gen1, accept 0x11,0x22, drop RxValid for 1 cycle, then 0x55,0x66,0x77,0x88 -> single strobe 0x88776655; with PIPE_RX_DROP_CNT_EN, rxDropCount=1.
- Gen1 partial (2 bytes), generation switched to 4 with RxData=0xCAFEF00D valid on the switch cycle, then 0x12345678 -> switch-cycle word ignored, strobe 0x12345678 only; drop count increments by 1.
- Reset asserted after 3 Gen1 bytes -> outputs 0 the next cycle; 4 new bytes after release produce exactly one correct word; generation=7 with valid input produces no strobe.
